ram_io_responder: RTL and testbench
===================================

Name: ram_io_responder

Overview:
- Target end of the byte-wide memory bus (mem_a / mem_wr / mem_dout / mem_din) that mem_ctrl drives.
- Serves a byte-addressed RAM with one-cycle registered read latency.
- Also serves a small memory-mapped IO window: an rx FIFO, a tx FIFO, a status register and a sticky halt flag.
- Includes a bench/boot preload port for filling RAM before the core runs.

Parameters:
- ADDR_WIDTH, 17, RAM address bits; RAM size is 2^ADDR_WIDTH bytes.
- FIFO_DEPTH, 16, entries per IO FIFO; must be a power of two, minimum 2.
- FIFO_PTR_W, 4, log2(FIFO_DEPTH).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-low reset
- mem_a  input  32  byte address from mem_ctrl
- mem_wr  input  1  1 = write mem_dout to mem_a this edge; 0 = read
- mem_dout  input  8  write data from mem_ctrl
- mem_din  output  8  read data, valid one cycle after the address is presented
- init_we  input  1  preload write strobe; overrides the bus when high
- init_addr  input  ADDR_WIDTH  preload byte address
- init_data  input  8  preload byte
- rx_valid  input  1  external byte offered to the rx FIFO
- rx_data  input  8  external rx byte
- rx_ready  output  1  rx FIFO not full
- tx_valid  output  1  tx FIFO not empty; tx_data is valid
- tx_data  output  8  head byte of the tx FIFO
- tx_ready  input  1  sink accepts tx_data this edge
- halt  output  1  sticky program-halt flag
- tx_overflow  output  1  sticky flag: a tx write was dropped

Behaviour:
- Address decode:
  - IO when mem_a[17:16] == 2'b11; otherwise RAM at mem_a[ADDR_WIDTH-1:0].
  - IO registers: 0x30000 = DATA, 0x30004 = STATUS; all other IO addresses read 0 and ignore writes.
- Reset (rst low, asynchronous):
  - mem_din = 0, halt = 0, tx_overflow = 0.
  - Both FIFOs empty, so tx_valid = 0, rx_ready = 1, tx_data = 0.
  - RAM contents are not reset.
- RAM write: at a clk edge with mem_wr=1 and mem_a in RAM space, store mem_dout at that address. mem_din is unchanged that cycle.
- RAM read: at a clk edge with mem_wr=0, mem_din <= RAM[addr].
  - Latency is exactly 1 cycle; back-to-back addresses yield back-to-back bytes.
  - A read of a byte written on the previous edge returns the new value.
- Preload: init_we=1 writes init_data to init_addr. The bus is ignored that cycle (no write, no FIFO pop, mem_din holds).
- DATA write: pushes mem_dout into the tx FIFO. If the FIFO is full, the byte is dropped and tx_overflow is set; it stays set until reset.
- DATA read:
  - mem_din <= rx FIFO head, or 0x00 if the FIFO is empty.
  - The pop happens only on the first cycle of a run of consecutive DATA reads (edge-detected on a registered "last access was a DATA read" bit), so mem_ctrl holding the address for several cycles pops once.
  - The popped value is held on mem_din for the whole run.
- STATUS read: mem_din <= {5'b0, halt, rx_nonempty, tx_full}.
- STATUS write: any value sets halt; halt stays set until reset.
- rx FIFO:
  - Pushes when rx_valid && rx_ready.
  - A simultaneous push and pop on a full FIFO is allowed: count unchanged, rx_ready stays 0.
  - A simultaneous push and pop on an empty FIFO returns 0x00 and leaves the new byte stored.
- tx FIFO:
  - Pops when tx_valid && tx_ready.
  - A simultaneous bus push and tx pop on a full FIFO succeeds, with no overflow.
  - tx_data is combinational from the head entry.
- Pointers: FIFO_PTR_W+1 bits with an extra wrap bit. Full when the MSBs differ and the low bits are equal; empty when the pointers are equal. Pointers wrap modulo 2*FIFO_DEPTH.
- Reset mid-operation: FIFOs, flags and mem_din clear immediately; the DATA-read edge detector clears, so the next DATA read pops.

Test Plan:
- Preload 0x00..0x03 with 0x13,0x05,0x00,0x00; present a=0,1,2,3 on successive cycles -> mem_din = 0x13,0x05,0x00,0x00 one cycle later each; mem_ctrl's IF sequence assembles inst 0x00000513.
- Bus write 0xAB to 0x100, then read 0x100 the next cycle -> mem_din=0xAB; write-then-read at 0x1FFFF (last byte) -> correct value, no aliasing into IO.
- Push rx bytes 0x41,0x42; hold a=0x30000 read for 3 cycles -> mem_din=0x41 for all 3 cycles, one pop only; re-present -> 0x42; again -> 0x00 (empty).
- tx_ready=0, write 17 bytes to 0x30000 (depth 16) -> tx_valid=1, tx_overflow=1, 16 stored; raise tx_ready -> tx_data 0x00..0x0F in order, then tx_valid=0.
- Read 0x30004 with rx non-empty and tx full -> mem_din=0x03; write 0x30004 -> halt=1, next STATUS read = 0x07.
- Assert rst low mid-run with FIFOs non-empty and halt=1 -> all outputs zero asynchronously, rx_ready=1; RAM byte at 0x100 still 0xAB after release.

Source files
------------

// File: rtl/ram_io_responder.sv
// ram_io_responder: target end of the byte-wide memory bus driven by mem_ctrl.
// Serves a byte-addressed RAM with one-cycle registered reads, a small IO
// window (rx FIFO, tx FIFO, status, sticky halt) and a preload port that
// overrides the bus while it is writing.
module ram_io_responder #(
    parameter int ADDR_WIDTH = 17,
    parameter int FIFO_DEPTH = 16,
    parameter int FIFO_PTR_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           mem_a,
    input  logic                  mem_wr,
    input  logic [7:0]            mem_dout,
    output logic [7:0]            mem_din,
    input  logic                  init_we,
    input  logic [ADDR_WIDTH-1:0] init_addr,
    input  logic [7:0]            init_data,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    output logic                  rx_ready,
    output logic                  tx_valid,
    output logic [7:0]            tx_data,
    input  logic                  tx_ready,
    output logic                  halt,
    output logic                  tx_overflow
);

    localparam int RAM_BYTES = 1 << ADDR_WIDTH;
    localparam logic [FIFO_PTR_W:0] PTR_ONE = {{FIFO_PTR_W{1'b0}}, 1'b1};

    // Storage: RAM and the two FIFO bodies are never reset
    logic [7:0] r_ram    [RAM_BYTES];
    logic [7:0] r_rx_mem [FIFO_DEPTH];
    logic [7:0] r_tx_mem [FIFO_DEPTH];

    logic [7:0]          r_ram_q;
    logic [7:0]          r_io_q;
    logic                r_src_ram;
    logic                r_last_data_rd;
    logic                r_halt;
    logic                r_tx_ovf;
    logic [FIFO_PTR_W:0] r_rx_wr;
    logic [FIFO_PTR_W:0] r_rx_rd;
    logic [FIFO_PTR_W:0] r_tx_wr;
    logic [FIFO_PTR_W:0] r_tx_rd;

    logic                  w_bus_rd;
    logic                  w_bus_wr;
    logic                  w_is_io;
    logic                  w_io_data;
    logic                  w_io_stat;
    logic [ADDR_WIDTH-1:0] w_ram_addr;
    logic                  w_rx_empty;
    logic                  w_rx_full;
    logic                  w_tx_empty;
    logic                  w_tx_full;
    logic                  w_data_rd_first;
    logic                  w_rx_pop;
    logic                  w_rx_push;
    logic                  w_tx_pop;
    logic                  w_data_wr;
    logic                  w_tx_push;
    logic                  w_tx_drop;
    logic [7:0]            w_rx_head;
    logic [7:0]            w_io_next;
    logic                  w_unused_hi;

    // Upper address bits play no part in decode
    assign w_unused_hi = ^mem_a[31:18];

    // Preload owns the cycle whenever init_we is high
    assign w_bus_rd   = !init_we && !mem_wr;
    assign w_bus_wr   = !init_we && mem_wr;
    assign w_is_io    = (mem_a[17:16] == 2'b11);
    assign w_io_data  = w_is_io && (mem_a[15:0] == 16'h0000);
    assign w_io_stat  = w_is_io && (mem_a[15:0] == 16'h0004);
    assign w_ram_addr = mem_a[ADDR_WIDTH-1:0];

    assign w_rx_empty = (r_rx_wr == r_rx_rd);
    assign w_rx_full  = (r_rx_wr[FIFO_PTR_W] != r_rx_rd[FIFO_PTR_W]) &&
                        (r_rx_wr[FIFO_PTR_W-1:0] == r_rx_rd[FIFO_PTR_W-1:0]);
    assign w_tx_empty = (r_tx_wr == r_tx_rd);
    assign w_tx_full  = (r_tx_wr[FIFO_PTR_W] != r_tx_rd[FIFO_PTR_W]) &&
                        (r_tx_wr[FIFO_PTR_W-1:0] == r_tx_rd[FIFO_PTR_W-1:0]);

    // A held DATA read pops only on its first cycle
    assign w_data_rd_first = w_bus_rd && w_io_data && !r_last_data_rd;
    assign w_rx_pop  = w_data_rd_first && !w_rx_empty;
    // A pop frees the slot, so a full rx FIFO can still take a byte that edge
    assign w_rx_push = rx_valid && (!w_rx_full || w_rx_pop);
    assign w_rx_head = r_rx_mem[r_rx_rd[FIFO_PTR_W-1:0]];

    assign w_tx_pop  = !w_tx_empty && tx_ready;
    assign w_data_wr = w_bus_wr && w_io_data;
    assign w_tx_push = w_data_wr && (!w_tx_full || w_tx_pop);
    assign w_tx_drop = w_data_wr && w_tx_full && !w_tx_pop;

    assign rx_ready    = !w_rx_full;
    assign tx_valid    = !w_tx_empty;
    assign tx_data     = w_tx_empty ? 8'h00 : r_tx_mem[r_tx_rd[FIFO_PTR_W-1:0]];
    assign halt        = r_halt;
    assign tx_overflow = r_tx_ovf;
    assign mem_din     = r_src_ram ? r_ram_q : r_io_q;

    // Next IO read byte; holds unless the bus performs an IO read
    always_comb begin
        w_io_next = r_io_q;
        if (w_bus_rd && w_is_io) begin
            if (w_io_data) begin
                if (w_data_rd_first) begin
                    w_io_next = w_rx_empty ? 8'h00 : w_rx_head;
                end
            end else if (w_io_stat) begin
                w_io_next = {5'b0, r_halt, !w_rx_empty, w_tx_full};
            end else begin
                w_io_next = 8'h00;
            end
        end
    end

    // RAM write port (preload has priority) and registered RAM read
    always_ff @(posedge clk) begin
        if (init_we) begin
            r_ram[init_addr] <= init_data;
        end else if (mem_wr && !w_is_io) begin
            r_ram[w_ram_addr] <= mem_dout;
        end
        if (w_bus_rd && !w_is_io) begin
            r_ram_q <= r_ram[w_ram_addr];
        end
    end

    // FIFO body writes
    always_ff @(posedge clk) begin
        if (w_rx_push) begin
            r_rx_mem[r_rx_wr[FIFO_PTR_W-1:0]] <= rx_data;
        end
        if (w_tx_push) begin
            r_tx_mem[r_tx_wr[FIFO_PTR_W-1:0]] <= mem_dout;
        end
    end

    // Control state: read-source select, IO read byte, pointers, sticky flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_src_ram      <= 1'b0;
            r_io_q         <= 8'h00;
            r_last_data_rd <= 1'b0;
            r_halt         <= 1'b0;
            r_tx_ovf       <= 1'b0;
            r_rx_wr        <= '0;
            r_rx_rd        <= '0;
            r_tx_wr        <= '0;
            r_tx_rd        <= '0;
        end else begin
            r_io_q <= w_io_next;
            if (w_bus_rd) begin
                r_src_ram <= !w_is_io;
            end
            if (!init_we) begin
                r_last_data_rd <= w_bus_rd && w_io_data;
            end
            if (w_bus_wr && w_io_stat) begin
                r_halt <= 1'b1;
            end
            if (w_tx_drop) begin
                r_tx_ovf <= 1'b1;
            end
            if (w_rx_push) r_rx_wr <= r_rx_wr + PTR_ONE;
            if (w_rx_pop)  r_rx_rd <= r_rx_rd + PTR_ONE;
            if (w_tx_push) r_tx_wr <= r_tx_wr + PTR_ONE;
            if (w_tx_pop)  r_tx_rd <= r_tx_rd + PTR_ONE;
        end
    end

endmodule

// File: tb/tb_ram_io_responder.sv
// Directed bench for ram_io_responder: RAM preload/read/write, rx and tx
// FIFOs, status/halt and asynchronous reset in the middle of traffic.
module tb_ram_io_responder;

    logic        clk;
    logic        rst;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic [7:0]  mem_dout;
    logic [7:0]  mem_din;
    logic        init_we;
    logic [16:0] init_addr;
    logic [7:0]  init_data;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        halt;
    logic        tx_overflow;

    int total;
    int bad;

    localparam logic [31:0] IDLE_A = 32'h0003_0008;
    localparam logic [31:0] DATA_A = 32'h0003_0000;
    localparam logic [31:0] STAT_A = 32'h0003_0004;

    ram_io_responder #(
        .ADDR_WIDTH(17),
        .FIFO_DEPTH(16),
        .FIFO_PTR_W(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_a      (mem_a),
        .mem_wr     (mem_wr),
        .mem_dout   (mem_dout),
        .mem_din    (mem_din),
        .init_we    (init_we),
        .init_addr  (init_addr),
        .init_data  (init_data),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_ready   (tx_ready),
        .halt       (halt),
        .tx_overflow(tx_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One bus cycle: drive on the falling edge, return 1 after the rising edge
    task automatic cyc(input logic [31:0] a, input logic wr, input logic [7:0] d,
                       input logic rv, input logic [7:0] rd);
        @(negedge clk);
        init_we  = 1'b0;
        mem_a    = a;
        mem_wr   = wr;
        mem_dout = d;
        rx_valid = rv;
        rx_data  = rd;
        @(posedge clk);
        #1;
        $display("cyc a=%h wr=%0d d=%h rx=%0d/%h -> din=%h txv=%0d txd=%h",
                 a, wr, d, rv, rd, mem_din, tx_valid, tx_data);
    endtask

    task automatic preload(input logic [16:0] a, input logic [7:0] d);
        @(negedge clk);
        init_we   = 1'b1;
        init_addr = a;
        init_data = d;
        mem_a     = IDLE_A;
        mem_wr    = 1'b0;
        rx_valid  = 1'b0;
        @(posedge clk);
        #1;
        $display("preload a=%h d=%h", a, d);
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (mem_din !== 8'h00) begin bad++; $display("FAIL reset_din: got %h want 00", mem_din); end
        total++; if (halt !== 1'b0) begin bad++; $display("FAIL reset_halt: got %b want 0", halt); end
        total++; if (tx_overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %b want 0", tx_overflow); end
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL reset_txv: got %b want 0", tx_valid); end
        total++; if (rx_ready !== 1'b1) begin bad++; $display("FAIL reset_rxr: got %b want 1", rx_ready); end
        total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL reset_txd: got %h want 00", tx_data); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_preload;
        logic [7:0] b0, b1, b2, b3;
        preload(17'h0, 8'h13);
        preload(17'h1, 8'h05);
        preload(17'h2, 8'h00);
        preload(17'h3, 8'h00);
        cyc(32'h0, 1'b0, 8'h00, 1'b0, 8'h00); b0 = mem_din;
        total++; if (mem_din !== 8'h13) begin bad++; $display("FAIL pre_b0: got %h want 13", mem_din); end
        cyc(32'h1, 1'b0, 8'h00, 1'b0, 8'h00); b1 = mem_din;
        total++; if (mem_din !== 8'h05) begin bad++; $display("FAIL pre_b1: got %h want 05", mem_din); end
        // preload cycle with a read address on the bus: mem_din must hold
        @(negedge clk);
        init_we = 1'b1; init_addr = 17'h200; init_data = 8'h77;
        mem_a = 32'h0; mem_wr = 1'b0;
        @(posedge clk); #1;
        total++; if (mem_din !== 8'h05) begin bad++; $display("FAIL pre_hold: got %h want 05", mem_din); end
        cyc(32'h2, 1'b0, 8'h00, 1'b0, 8'h00); b2 = mem_din;
        total++; if (mem_din !== 8'h00) begin bad++; $display("FAIL pre_b2: got %h want 00", mem_din); end
        cyc(32'h3, 1'b0, 8'h00, 1'b0, 8'h00); b3 = mem_din;
        total++; if ({b3, b2, b1, b0} !== 32'h0000_0513) begin bad++; $display("FAIL pre_inst: got %h want 00000513", {b3, b2, b1, b0}); end
        cyc(32'h200, 1'b0, 8'h00, 1'b0, 8'h00);
        total++; if (mem_din !== 8'h77) begin bad++; $display("FAIL pre_0x200: got %h want 77", mem_din); end
    endtask

    task automatic test_ram_rw;
        cyc(32'h100, 1'b1, 8'hAB, 1'b0, 8'h00);
        total++; if (mem_din !== 8'h77) begin bad++; $display("FAIL wr_hold: got %h want 77", mem_din); end
        cyc(32'h100, 1'b0, 8'h00, 1'b0, 8'h00);
        total++; if (mem_din !== 8'hAB) begin bad++; $display("FAIL rd_0x100: got %h want AB", mem_din); end
        cyc(32'h101, 1'b1, 8'hCD, 1'b0, 8'h00);
        cyc(32'h100, 1'b0, 8'h00, 1'b0, 8'h00);
        total++; if (mem_din !== 8'hAB) begin bad++; $display("FAIL b2b_0x100: got %h want AB", mem_din); end
        cyc(32'h101, 1'b0, 8'h00, 1'b0, 8'h00);
        total++; if (mem_din !== 8'hCD) begin bad++; $display("FAIL b2b_0x101: got %h want CD", mem_din); end
        cyc(32'h1FFFF, 1'b1, 8'h5A, 1'b0, 8'h00);
        cyc(32'h1FFFF, 1'b0, 8'h00, 1'b0, 8'h00);
        total++; if (mem_din !== 8'h5A) begin bad++; $display("FAIL rd_last: got %h want 5A", mem_din); end
        cyc(STAT_A, 1'b0, 8'h00, 1'b0, 8'h00);
        total++; if (mem_din !== 8'h00) begin bad++; $display("FAIL no_alias_stat: got %h want 00", mem_din); end
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL no_alias_txv: got %b want 0", tx_valid); end
    endtask

    task automatic test_rx_fifo;
        cyc(IDLE_A, 1'b0, 8'h00, 1'b1, 8'h41);
        total++; if (mem_din !== 8'h00) begin bad++; $display("FAIL rx_idle_io: got %h want 00", mem_din); end
        cyc(IDLE_A, 1'b0, 8'h00, 1'b1, 8'h42);
        total++; if (rx_ready !== 1'b1) begin bad++; $display("FAIL rx_ready: got %b want 1", rx_ready); end
        for (int i = 0; i < 3; i++) begin
            cyc(DATA_A, 1'b0, 8'h00, 1'b0, 8'h00);
            total++; if (mem_din !== 8'h41) begin bad++; $display("FAIL rx_hold%0d: got %h want 41", i, mem_din); end
        end
        cyc(IDLE_A, 1'b0, 8'h00, 1'b0, 8'h00);
        cyc(DATA_A, 1'b0, 8'h00, 1'b0, 8'h00);
        total++; if (mem_din !== 8'h42) begin bad++; $display("FAIL rx_second: got %h want 42", mem_din); end
        cyc(IDLE_A, 1'b0, 8'h00, 1'b0, 8'h00);
        cyc(DATA_A, 1'b0, 8'h00, 1'b0, 8'h00);
        total++; if (mem_din !== 8'h00) begin bad++; $display("FAIL rx_empty: got %h want 00", mem_din); end
        cyc(IDLE_A, 1'b0, 8'h00, 1'b0, 8'h00);
    endtask

    task automatic test_tx_overflow;
        tx_ready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            cyc(DATA_A, 1'b1, 8'(i), 1'b0, 8'h00);
            if (i == 15) begin
                total++; if (tx_overflow !== 1'b0) begin bad++; $display("FAIL tx_ovf_early: got %b want 0", tx_overflow); end
            end
        end
        total++; if (tx_overflow !== 1'b1) begin bad++; $display("FAIL tx_ovf: got %b want 1", tx_overflow); end
        total++; if (tx_valid !== 1'b1) begin bad++; $display("FAIL tx_valid_full: got %b want 1", tx_valid); end
        total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL tx_head: got %h want 00", tx_data); end
    endtask

    task automatic test_status;
        cyc(IDLE_A, 1'b0, 8'h00, 1'b1, 8'h55);
        cyc(STAT_A, 1'b0, 8'h00, 1'b0, 8'h00);
        total++; if (mem_din !== 8'h03) begin bad++; $display("FAIL stat_03: got %h want 03", mem_din); end
        cyc(STAT_A, 1'b1, 8'h00, 1'b0, 8'h00);
        total++; if (halt !== 1'b1) begin bad++; $display("FAIL halt_set: got %b want 1", halt); end
        total++; if (mem_din !== 8'h03) begin bad++; $display("FAIL stat_wr_hold: got %h want 03", mem_din); end
        cyc(STAT_A, 1'b0, 8'h00, 1'b0, 8'h00);
        total++; if (mem_din !== 8'h07) begin bad++; $display("FAIL stat_07: got %h want 07", mem_din); end
    endtask

    task automatic test_tx_drain;
        cyc(IDLE_A, 1'b0, 8'h00, 1'b0, 8'h00);
        @(negedge clk);
        tx_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            #1;
            total++; if (tx_valid !== 1'b1 || tx_data !== 8'(i)) begin bad++; $display("FAIL tx_drain%0d: got v=%b d=%h want v=1 d=%h", i, tx_valid, tx_data, 8'(i)); end
            $display("tx pop d=%h", tx_data);
            @(negedge clk);
        end
        #1;
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL tx_drained: got %b want 0", tx_valid); end
        total++; if (tx_overflow !== 1'b1) begin bad++; $display("FAIL tx_ovf_sticky: got %b want 1", tx_overflow); end
        tx_ready = 1'b0;
    endtask

    task automatic test_reset_mid;
        cyc(DATA_A, 1'b1, 8'hE1, 1'b0, 8'h00);
        cyc(DATA_A, 1'b1, 8'hE2, 1'b0, 8'h00);
        total++; if (tx_valid !== 1'b1 || tx_data !== 8'hE1) begin bad++; $display("FAIL mid_tx: got v=%b d=%h want v=1 d=E1", tx_valid, tx_data); end
        cyc(DATA_A, 1'b0, 8'h00, 1'b0, 8'h00);
        total++; if (mem_din !== 8'h55) begin bad++; $display("FAIL mid_rx: got %h want 55", mem_din); end
        // DATA read still held; drop reset between clock edges
        #2;
        rst = 1'b0;
        #1;
        total++; if (mem_din !== 8'h00) begin bad++; $display("FAIL arst_din: got %h want 00", mem_din); end
        total++; if (halt !== 1'b0 || tx_overflow !== 1'b0) begin bad++; $display("FAIL arst_flags: got halt=%b ovf=%b want 0 0", halt, tx_overflow); end
        total++; if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin bad++; $display("FAIL arst_tx: got v=%b d=%h want 0 00", tx_valid, tx_data); end
        total++; if (rx_ready !== 1'b1) begin bad++; $display("FAIL arst_rxr: got %b want 1", rx_ready); end
        @(negedge clk);
        @(negedge clk);
        // release with a preload cycle while an rx byte arrives; DATA read stays on the bus
        rst = 1'b1;
        init_we = 1'b1; init_addr = 17'h300; init_data = 8'h11;
        rx_valid = 1'b1; rx_data = 8'h66;
        @(posedge clk); #1;
        total++; if (mem_din !== 8'h00) begin bad++; $display("FAIL post_init_hold: got %h want 00", mem_din); end
        @(negedge clk);
        init_we = 1'b0; rx_valid = 1'b0;
        @(posedge clk); #1;
        total++; if (mem_din !== 8'h66) begin bad++; $display("FAIL post_rst_pop: got %h want 66", mem_din); end
        cyc(32'h100, 1'b0, 8'h00, 1'b0, 8'h00);
        total++; if (mem_din !== 8'hAB) begin bad++; $display("FAIL ram_kept: got %h want AB", mem_din); end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        mem_a     = IDLE_A;
        mem_wr    = 1'b0;
        mem_dout  = 8'h00;
        init_we   = 1'b0;
        init_addr = '0;
        init_data = 8'h00;
        rx_valid  = 1'b0;
        rx_data   = 8'h00;
        tx_ready  = 1'b0;
        test_reset();
        test_preload();
        test_ram_rw();
        test_rx_fifo();
        test_tx_overflow();
        test_status();
        test_tx_drain();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
